// File: rtl/decode_unit_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate formats and the control-bit table.
package decode_unit_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    typedef struct packed {
        logic      reg_write;
        logic      alu_src_imm;
        logic      mem_read;
        logic      mem_write;
        logic      branch;
        logic      jump;
        logic      illegal;
        logic      uses_rs1;
        logic      uses_rs2;
        imm_type_e imm_type;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // The all-zero word is fetch's reset value and must decode as a bubble, not as illegal.
    function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
        ctrl_t c;
        c = CTRL_BUBBLE;
        if (instr != '0) begin
            c.uses_rs1 = 1'b1;
            case (instr[6:0])
                OPC_LUI: begin
                    c.reg_write = 1'b1; c.alu_src_imm = 1'b1; c.imm_type = IMM_U; c.uses_rs1 = 1'b0;
                end
                OPC_AUIPC: begin
                    c.reg_write = 1'b1; c.alu_src_imm = 1'b1; c.imm_type = IMM_U; c.uses_rs1 = 1'b0;
                end
                OPC_JAL: begin
                    c.reg_write = 1'b1; c.jump = 1'b1; c.imm_type = IMM_J; c.uses_rs1 = 1'b0;
                end
                OPC_JALR: begin
                    c.reg_write = 1'b1; c.jump = 1'b1; c.alu_src_imm = 1'b1; c.imm_type = IMM_I;
                end
                OPC_BRANCH: begin
                    c.branch = 1'b1; c.imm_type = IMM_B; c.uses_rs2 = 1'b1;
                end
                OPC_LOAD: begin
                    c.reg_write = 1'b1; c.mem_read = 1'b1; c.alu_src_imm = 1'b1; c.imm_type = IMM_I;
                end
                OPC_STORE: begin
                    c.mem_write = 1'b1; c.alu_src_imm = 1'b1; c.imm_type = IMM_S; c.uses_rs2 = 1'b1;
                end
                OPC_OPIMM: begin
                    c.reg_write = 1'b1; c.alu_src_imm = 1'b1; c.imm_type = IMM_I;
                end
                OPC_OP: begin
                    c.reg_write = 1'b1; c.uses_rs2 = 1'b1;
                end
                default: c.illegal = 1'b1;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/decode_unit_imm_gen.sv
// Combinational RV32I immediate generator; the sign bit is always instr[31].
module imm_gen
    import decode_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       instr,
    input  logic [2:0]        imm_sel,
    output logic [DATA_W-1:0] imm
);

    logic signed [31:0] imm32;
    logic               unused_opcode;

    assign unused_opcode = ^instr[6:0];

    // NOTE: every variable written in always_comb gets a default first, otherwise an
    // unlisted case leaves it holding its old value and a latch is inferred.
    always_comb begin
        imm32 = '0;
        case (imm_sel)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = DATA_W'(imm32);

endmodule

// File: rtl/decode_unit.sv
// RV32I decode stage: register-file addressing, control decode, load-use detection and the ID/EX register.
module decode_unit
    import decode_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              stage_clk,
    input  logic              reset,
    input  logic              stage_ena,
    input  logic              stage_x,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] pc_next_in,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [DATA_W-1:0] rs1_rdata,
    input  logic [DATA_W-1:0] rs2_rdata,
    output logic              hazard_stall,
    output logic              valid,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pc_next,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] imm,
    output logic [REG_AW-1:0] rd,
    output logic [2:0]        funct3,
    output logic              funct7b5,
    output logic              alu_src_imm,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch,
    output logic              jump,
    output logic              illegal
);

    ctrl_t             ctrl;
    logic [DATA_W-1:0] imm_val;
    logic              hazard_raw;
    logic              load_bubble;
    logic              load_decode;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q, pc_d, pc_next_q, pc_next_d;
    logic [DATA_W-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              funct7b5_q, funct7b5_d;
    logic              alu_src_imm_q, alu_src_imm_d, reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic              branch_q, branch_d, jump_q, jump_d, illegal_q, illegal_d;

    assign rs1_addr = REG_AW'(instr_in[19:15]);
    assign rs2_addr = REG_AW'(instr_in[24:20]);
    assign ctrl     = decode_ctrl(instr_in[31:0]);

    imm_gen #(.DATA_W(DATA_W)) u_imm_gen (
        .instr   (instr_in[31:0]),
        .imm_sel (ctrl.imm_type),
        .imm     (imm_val)
    );

    always_comb begin
        hazard_raw = valid_q & mem_read_q & (rd_q != '0) &
                     (((rd_q == rs1_addr) & ctrl.uses_rs1) | ((rd_q == rs2_addr) & ctrl.uses_rs2));
    end

    assign hazard_stall = hazard_raw & ~stage_x;

    // Flush wins over hold; a hazard or the all-zero fetch word only inserts a bubble when advancing.
    assign load_bubble = stage_x | (stage_ena & (hazard_raw | (instr_in == '0)));
    assign load_decode = stage_ena & ~load_bubble;

    always_comb begin
        valid_d       = valid_q;
        pc_d          = pc_q;
        pc_next_d     = pc_next_q;
        rs1_data_d    = rs1_data_q;
        rs2_data_d    = rs2_data_q;
        imm_d         = imm_q;
        rd_d          = rd_q;
        funct3_d      = funct3_q;
        funct7b5_d    = funct7b5_q;
        alu_src_imm_d = alu_src_imm_q;
        reg_write_d   = reg_write_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        branch_d      = branch_q;
        jump_d        = jump_q;
        illegal_d     = illegal_q;

        if (load_bubble) begin
            valid_d       = 1'b0;
            pc_d          = '0;
            pc_next_d     = '0;
            rs1_data_d    = '0;
            rs2_data_d    = '0;
            imm_d         = '0;
            rd_d          = '0;
            funct3_d      = '0;
            funct7b5_d    = 1'b0;
            alu_src_imm_d = 1'b0;
            reg_write_d   = 1'b0;
            mem_read_d    = 1'b0;
            mem_write_d   = 1'b0;
            branch_d      = 1'b0;
            jump_d        = 1'b0;
            illegal_d     = 1'b0;
        end else if (load_decode) begin
            valid_d       = 1'b1;
            pc_d          = pc_in;
            pc_next_d     = pc_next_in;
            rs1_data_d    = rs1_rdata;
            rs2_data_d    = rs2_rdata;
            imm_d         = imm_val;
            rd_d          = ctrl.reg_write ? REG_AW'(instr_in[11:7]) : '0;
            funct3_d      = instr_in[14:12];
            funct7b5_d    = instr_in[30];
            alu_src_imm_d = ctrl.alu_src_imm;
            reg_write_d   = ctrl.reg_write;
            mem_read_d    = ctrl.mem_read;
            mem_write_d   = ctrl.mem_write;
            branch_d      = ctrl.branch;
            jump_d        = ctrl.jump;
            illegal_d     = ctrl.illegal;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples its
    // input from before the edge, independent of statement order.
    always_ff @(posedge stage_clk or posedge reset) begin
        if (reset) begin
            valid_q       <= 1'b0;
            pc_q          <= '0;
            pc_next_q     <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            rd_q          <= '0;
            funct3_q      <= '0;
            funct7b5_q    <= 1'b0;
            alu_src_imm_q <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            branch_q      <= 1'b0;
            jump_q        <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            pc_q          <= pc_d;
            pc_next_q     <= pc_next_d;
            rs1_data_q    <= rs1_data_d;
            rs2_data_q    <= rs2_data_d;
            imm_q         <= imm_d;
            rd_q          <= rd_d;
            funct3_q      <= funct3_d;
            funct7b5_q    <= funct7b5_d;
            alu_src_imm_q <= alu_src_imm_d;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            branch_q      <= branch_d;
            jump_q        <= jump_d;
            illegal_q     <= illegal_d;
        end
    end

    assign valid       = valid_q;
    assign pc          = pc_q;
    assign pc_next     = pc_next_q;
    assign rs1_data    = rs1_data_q;
    assign rs2_data    = rs2_data_q;
    assign imm         = imm_q;
    assign rd          = rd_q;
    assign funct3      = funct3_q;
    assign funct7b5    = funct7b5_q;
    assign alu_src_imm = alu_src_imm_q;
    assign reg_write   = reg_write_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign branch      = branch_q;
    assign jump        = jump_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_decode_unit.sv
// Directed-vector bench for decode_unit: reset, decode formats, load-use hazard, hold and flush.
module tb_decode_unit;

    logic        stage_clk = 1'b0;
    logic        reset;
    logic        stage_ena;
    logic        stage_x;
    logic [31:0] instr_in, pc_in, pc_next_in, rs1_rdata, rs2_rdata;
    logic [4:0]  rs1_addr, rs2_addr, rd;
    logic        hazard_stall, valid, funct7b5;
    logic [31:0] pc, pc_next, rs1_data, rs2_data, imm;
    logic [2:0]  funct3;
    logic        alu_src_imm, reg_write, mem_read, mem_write, branch, jump, illegal;

    int checks = 0;
    int errors = 0;

    // Control vector order: valid, reg_write, mem_read, mem_write, branch, jump, alu_src_imm, illegal
    logic [7:0] ctl;
    assign ctl = {valid, reg_write, mem_read, mem_write, branch, jump, alu_src_imm, illegal};

    localparam logic [7:0] CTL_BUBBLE  = 8'b0000_0000;
    localparam logic [7:0] CTL_OPIMM   = 8'b1100_0010;
    localparam logic [7:0] CTL_LOAD    = 8'b1110_0010;
    localparam logic [7:0] CTL_OP      = 8'b1100_0000;
    localparam logic [7:0] CTL_BRANCH  = 8'b1000_1000;
    localparam logic [7:0] CTL_STORE   = 8'b1001_0010;
    localparam logic [7:0] CTL_JAL     = 8'b1100_0100;
    localparam logic [7:0] CTL_ILLEGAL = 8'b1000_0001;

    localparam logic [31:0] I_ADDI = 32'hFFF08293;  // addi x5, x1, -1
    localparam logic [31:0] I_LW   = 32'h00012303;  // lw   x6, 0(x2)
    localparam logic [31:0] I_ADD  = 32'h001303B3;  // add  x7, x6, x1
    localparam logic [31:0] I_BEQ  = 32'hFE208CE3;  // beq  x1, x2, -8
    localparam logic [31:0] I_SW   = 32'hFE512E23;  // sw   x5, -4(x2)
    localparam logic [31:0] I_LUI  = 32'h123451B7;  // lui  x3, 0x12345
    localparam logic [31:0] I_JAL  = 32'hFFDFF0EF;  // jal  x1, -4
    localparam logic [31:0] I_NOP0 = 32'h00000013;  // addi x0, x0, 0

    decode_unit #(.DATA_W(32), .REG_AW(5)) dut (
        .stage_clk    (stage_clk),
        .reset        (reset),
        .stage_ena    (stage_ena),
        .stage_x      (stage_x),
        .instr_in     (instr_in),
        .pc_in        (pc_in),
        .pc_next_in   (pc_next_in),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_rdata    (rs1_rdata),
        .rs2_rdata    (rs2_rdata),
        .hazard_stall (hazard_stall),
        .valid        (valid),
        .pc           (pc),
        .pc_next      (pc_next),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm          (imm),
        .rd           (rd),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .alu_src_imm  (alu_src_imm),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .branch       (branch),
        .jump         (jump),
        .illegal      (illegal)
    );

    always #5 stage_clk = ~stage_clk;

    task automatic step();
        @(posedge stage_clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pcv,
                         input logic [31:0] r1, input logic [31:0] r2);
        instr_in   = instr;
        pc_in      = pcv;
        pc_next_in = pcv + 32'd4;
        rs1_rdata  = r1;
        rs2_rdata  = r2;
    endtask

    task automatic test_reset();
        reset = 1'b1; stage_ena = 1'b1; stage_x = 1'b0;
        drive(I_ADDI, 32'h0000_0040, 32'h10, 32'h0);
        step(); step();
        checks++; if (ctl !== CTL_BUBBLE) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_BUBBLE); end
        checks++; if ({imm, pc, rd} !== '0) begin errors++; $display("FAIL reset_data: imm %h pc %h rd %0d expected all zero", imm, pc, rd); end
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL reset_hazard: got %b expected 0", hazard_stall); end
        reset = 1'b0;
        step();
        checks++; if (ctl !== CTL_OPIMM) begin errors++; $display("FAIL pre_reset_ctl: got %b expected %b", ctl, CTL_OPIMM); end
        #2 reset = 1'b1;
        #1;
        checks++; if (ctl !== CTL_BUBBLE) begin errors++; $display("FAIL midreset_ctl: got %b expected %b", ctl, CTL_BUBBLE); end
        checks++; if ({imm, pc, pc_next, rs1_data, rd} !== '0) begin
            errors++; $display("FAIL midreset_data: imm %h pc %h rs1_data %h rd %0d expected all zero", imm, pc, rs1_data, rd);
        end
        #1 reset = 1'b0;
        step();
        checks++; if (ctl !== CTL_OPIMM || rd !== 5'd5) begin
            errors++; $display("FAIL post_reset_decode: ctl %b rd %0d expected %b rd 5", ctl, rd, CTL_OPIMM);
        end
    endtask

    task automatic test_addi();
        drive(I_ADDI, 32'h0000_0100, 32'h10, 32'h22);
        #1;
        checks++; if (rs1_addr !== 5'd1 || rs2_addr !== 5'd31) begin
            errors++; $display("FAIL addi_rs_addr: rs1 %0d rs2 %0d expected 1 31", rs1_addr, rs2_addr);
        end
        step();
        checks++; if (ctl !== CTL_OPIMM) begin errors++; $display("FAIL addi_ctl: got %b expected %b", ctl, CTL_OPIMM); end
        checks++; if (imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL addi_imm: got %h expected ffffffff", imm); end
        checks++; if (rd !== 5'd5) begin errors++; $display("FAIL addi_rd: got %0d expected 5", rd); end
        checks++; if (rs1_data !== 32'h10 || rs2_data !== 32'h22) begin
            errors++; $display("FAIL addi_operands: got %h %h expected 00000010 00000022", rs1_data, rs2_data);
        end
        checks++; if (pc !== 32'h100 || pc_next !== 32'h104) begin
            errors++; $display("FAIL addi_pc: got %h %h expected 00000100 00000104", pc, pc_next);
        end
        checks++; if (funct3 !== 3'd0 || funct7b5 !== 1'b1) begin
            errors++; $display("FAIL addi_funct: got %0d %b expected 0 1", funct3, funct7b5);
        end
    endtask

    task automatic test_load_use();
        drive(I_LW, 32'h200, 32'h1000, 32'h0);
        step();
        checks++; if (ctl !== CTL_LOAD || rd !== 5'd6 || funct3 !== 3'd2) begin
            errors++; $display("FAIL lw_decode: ctl %b rd %0d f3 %0d expected %b 6 2", ctl, rd, funct3, CTL_LOAD);
        end
        drive(I_ADD, 32'h204, 32'h55, 32'h66);
        #1;
        checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b expected 1", hazard_stall); end
        stage_x = 1'b1;
        #1;
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_masked: got %b expected 0", hazard_stall); end
        stage_x = 1'b0;
        step();
        checks++; if (ctl !== CTL_BUBBLE || rd !== 5'd0) begin
            errors++; $display("FAIL lu_bubble: ctl %b rd %0d expected %b 0", ctl, rd, CTL_BUBBLE);
        end
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_clear: got %b expected 0", hazard_stall); end
        step();
        checks++; if (ctl !== CTL_OP || rd !== 5'd7 || imm !== 32'h0) begin
            errors++; $display("FAIL add_decode: ctl %b rd %0d imm %h expected %b 7 0", ctl, rd, imm, CTL_OP);
        end
        checks++; if (rs1_data !== 32'h55 || rs2_data !== 32'h66 || pc !== 32'h204) begin
            errors++; $display("FAIL add_data: %h %h pc %h expected 00000055 00000066 00000204", rs1_data, rs2_data, pc);
        end
        drive(I_LW, 32'h208, 32'h1000, 32'h0);
        step();
        drive(I_ADDI, 32'h20C, 32'h10, 32'h0);
        #1;
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_nodep: got %b expected 0", hazard_stall); end
        step();
        checks++; if (ctl !== CTL_OPIMM || rd !== 5'd5) begin
            errors++; $display("FAIL lu_nodep_decode: ctl %b rd %0d expected %b 5", ctl, rd, CTL_OPIMM);
        end
    endtask

    task automatic test_branch();
        drive(I_BEQ, 32'h300, 32'h1, 32'h2);
        step();
        checks++; if (ctl !== CTL_BRANCH) begin errors++; $display("FAIL beq_ctl: got %b expected %b", ctl, CTL_BRANCH); end
        checks++; if (imm !== 32'hFFFF_FFF8 || rd !== 5'd0) begin
            errors++; $display("FAIL beq_imm_rd: imm %h rd %0d expected fffffff8 0", imm, rd);
        end
        stage_x = 1'b1;
        step();
        stage_x = 1'b0;
        checks++; if (ctl !== CTL_BUBBLE || imm !== 32'h0) begin
            errors++; $display("FAIL beq_flush: ctl %b imm %h expected %b 0", ctl, imm, CTL_BUBBLE);
        end
    endtask

    task automatic test_hold();
        logic [31:0] hold_instr [3];
        hold_instr[0] = I_LUI; hold_instr[1] = I_BEQ; hold_instr[2] = I_SW;
        drive(I_ADDI, 32'h400, 32'h77, 32'h0);
        step();
        stage_ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(hold_instr[i], 32'h500 + 32'(i * 4), 32'h99, 32'h99);
            step();
            checks++; if (ctl !== CTL_OPIMM || pc !== 32'h400 || imm !== 32'hFFFF_FFFF || rd !== 5'd5 || rs1_data !== 32'h77) begin
                errors++; $display("FAIL hold_%0d: ctl %b pc %h imm %h rd %0d expected frozen ADDI at 00000400", i, ctl, pc, imm, rd);
            end
        end
        stage_x = 1'b1;
        step();
        checks++; if (ctl !== CTL_BUBBLE || pc !== 32'h0) begin
            errors++; $display("FAIL hold_flush: ctl %b pc %h expected %b 0", ctl, pc, CTL_BUBBLE);
        end
        stage_x = 1'b0; stage_ena = 1'b1;
    endtask

    task automatic test_formats();
        drive(I_SW, 32'h600, 32'h0, 32'h0);
        step();
        checks++; if (ctl !== CTL_STORE || imm !== 32'hFFFF_FFFC || rd !== 5'd0) begin
            errors++; $display("FAIL sw_decode: ctl %b imm %h rd %0d expected %b fffffffc 0", ctl, imm, rd, CTL_STORE);
        end
        drive(I_LUI, 32'h604, 32'h0, 32'h0);
        step();
        checks++; if (ctl !== CTL_OPIMM || imm !== 32'h1234_5000 || rd !== 5'd3) begin
            errors++; $display("FAIL lui_decode: ctl %b imm %h rd %0d expected %b 12345000 3", ctl, imm, rd, CTL_OPIMM);
        end
        drive(I_JAL, 32'h608, 32'h0, 32'h0);
        step();
        checks++; if (ctl !== CTL_JAL || imm !== 32'hFFFF_FFFC || rd !== 5'd1) begin
            errors++; $display("FAIL jal_decode: ctl %b imm %h rd %0d expected %b fffffffc 1", ctl, imm, rd, CTL_JAL);
        end
        drive(I_NOP0, 32'h60C, 32'h0, 32'h0);
        step();
        checks++; if (ctl !== CTL_OPIMM || rd !== 5'd0) begin
            errors++; $display("FAIL x0_write: ctl %b rd %0d expected %b 0", ctl, rd, CTL_OPIMM);
        end
    endtask

    task automatic test_illegal();
        drive(32'hFFFF_FFFF, 32'h700, 32'h0, 32'h0);
        step();
        checks++; if (ctl !== CTL_ILLEGAL || rd !== 5'd0 || imm !== 32'h0) begin
            errors++; $display("FAIL illegal_decode: ctl %b rd %0d imm %h expected %b 0 0", ctl, rd, imm, CTL_ILLEGAL);
        end
        drive(32'h0, 32'h704, 32'h0, 32'h0);
        step();
        checks++; if (ctl !== CTL_BUBBLE) begin errors++; $display("FAIL zero_instr: got %b expected %b", ctl, CTL_BUBBLE); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_branch();
        test_hold();
        test_formats();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
